// File: rtl/bot_if_pkg.sv
// rtl/bot_if_pkg.sv - shared constants and types for the multi-bot KCPSM6 interface
package bot_if_pkg;

    localparam int MAX_BOTS = 8;

    localparam logic [2:0] OFF_LOCX    = 3'd0;
    localparam logic [2:0] OFF_LOCY    = 3'd1;
    localparam logic [2:0] OFF_BOTINFO = 3'd2;
    localparam logic [2:0] OFF_SENSORS = 3'd3;
    localparam logic [2:0] OFF_LMDIST  = 3'd4;
    localparam logic [2:0] OFF_RMDIST  = 3'd5;
    localparam logic [2:0] OFF_RSVD    = 3'd6;
    localparam logic [2:0] OFF_MOTCTL  = 3'd7;

    localparam logic [6:0] ST_PEND = 7'h40;
    localparam logic [6:0] ST_SRC  = 7'h41;
    localparam logic [6:0] ST_MASK = 7'h42;
    localparam logic [6:0] ST_CLR  = 7'h43;
    localparam logic [6:0] ST_OVR  = 7'h44;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [2:0]   grant,
    output logic         valid
);

    logic [3:0] sum;
    logic       hit;

    always_comb begin
        grant = 3'd0;
        valid = 1'b0;
        sum   = 4'd0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(N)) begin
                sum = sum - 4'(N);
            end
            hit = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (sum == 4'(j)) begin
                    hit = req[j];
                end
            end
            if (!valid && hit) begin
                valid = 1'b1;
                grant = sum[2:0];
            end
        end
    end

endmodule

// File: rtl/multi_bot_if.sv
// rtl/multi_bot_if.sv - KCPSM6 port-bus interface to NUM_BOTS RojoBot channels with round-robin IRQ
module multi_bot_if
    import bot_if_pkg::*;
#(
    parameter int         NUM_BOTS  = 2,
    parameter logic [7:0] BASE_PORT = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            PortID,
    input  logic [7:0]            DataIn,
    output logic [7:0]            DataOut,
    input  logic                  WriteStrobe,
    input  logic                  ReadStrobe,
    output logic                  Interrupt,
    input  logic                  InterruptAck,
    output logic [8*NUM_BOTS-1:0] MotCtl,
    input  logic [8*NUM_BOTS-1:0] LocX,
    input  logic [8*NUM_BOTS-1:0] LocY,
    input  logic [8*NUM_BOTS-1:0] BotInfo,
    input  logic [8*NUM_BOTS-1:0] Sensors,
    input  logic [8*NUM_BOTS-1:0] LMDist,
    input  logic [8*NUM_BOTS-1:0] RMDist,
    input  logic [NUM_BOTS-1:0]   BotInterrupt
);

    localparam logic [3:0] NB4 = 4'(NUM_BOTS);

    // Snapshot packs the six CSRs with LocX in the low byte so offset*8 selects the field.
    logic [47:0]         snap_q   [NUM_BOTS];
    logic [47:0]         snap_d   [NUM_BOTS];
    logic [7:0]          motctl_q [NUM_BOTS];
    logic [7:0]          motctl_d [NUM_BOTS];
    logic [7:0]          dataout_q, dataout_d;
    logic [7:0]          mask_q, mask_d;
    logic [7:0]          src_q, src_d;
    logic [NUM_BOTS-1:0] pend_q, pend_d;
    logic [NUM_BOTS-1:0] ovr_q, ovr_d;
    logic [2:0]          ptr_q, ptr_d;
    logic                hold_q, hold_d;
    irq_state_e          state_q, state_d;

    logic                in_win, wr_win;
    logic [2:0]          bot_idx, bot_off;
    logic [NUM_BOTS-1:0] clr_bits, gclr, req;
    logic [2:0]          gnt;
    logic                gnt_vld;
    logic [3:0]          gnt_inc;
    logic                unused_rd;

    assign unused_rd = ReadStrobe;
    assign in_win    = (PortID[7] == BASE_PORT[7]);
    assign wr_win    = WriteStrobe && in_win;
    assign bot_idx   = PortID[5:3];
    assign bot_off   = PortID[2:0];
    assign req       = pend_q & mask_q[NUM_BOTS-1:0];
    assign gnt_inc   = {1'b0, gnt} + 4'd1;

    rr_arbiter #(.N(NUM_BOTS)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (gnt),
        .valid (gnt_vld)
    );

    always_comb begin
        dataout_d = 8'h00;
        if (in_win) begin
            if (!PortID[6]) begin
                for (int i = 0; i < NUM_BOTS; i++) begin
                    if (bot_idx == 3'(i)) begin
                        if (bot_off == OFF_MOTCTL) begin
                            dataout_d = motctl_q[i];
                        end else if (bot_off != OFF_RSVD) begin
                            dataout_d = snap_q[i][{bot_off, 3'b000} +: 8];
                        end
                    end
                end
            end else begin
                case (PortID[6:0])
                    ST_PEND: dataout_d = 8'(pend_q);
                    ST_SRC:  dataout_d = src_q;
                    ST_MASK: dataout_d = mask_q;
                    ST_OVR:  dataout_d = 8'(ovr_q);
                    default: dataout_d = 8'h00;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BOTS; i++) begin
            motctl_d[i] = motctl_q[i];
            if (wr_win && !PortID[6] && bot_idx == 3'(i) && bot_off == OFF_MOTCTL) begin
                motctl_d[i] = DataIn;
            end
            snap_d[i] = snap_q[i];
            if (BotInterrupt[i]) begin
                snap_d[i] = {RMDist[8*i +: 8], LMDist[8*i +: 8], Sensors[8*i +: 8],
                             BotInfo[8*i +: 8], LocY[8*i +: 8], LocX[8*i +: 8]};
            end
            MotCtl[8*i +: 8] = motctl_q[i];
        end
        mask_d   = (wr_win && PortID[6:0] == ST_MASK) ? DataIn : mask_q;
        clr_bits = (wr_win && PortID[6:0] == ST_CLR) ? DataIn[NUM_BOTS-1:0] : '0;
    end

    // hold_q keeps the line low for a second cycle after every ack.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        hold_d  = 1'b0;
        gclr    = '0;
        case (state_q)
            IRQ_IDLE: begin
                if (|req && !hold_q) begin
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (InterruptAck) begin
                    state_d = IRQ_IDLE;
                    hold_d  = 1'b1;
                    if (gnt_vld) begin
                        src_d = {1'b1, 4'b0000, gnt};
                        ptr_d = (gnt_inc == NB4) ? 3'd0 : gnt_inc[2:0];
                        for (int i = 0; i < NUM_BOTS; i++) begin
                            gclr[i] = (gnt == 3'(i));
                        end
                    end else begin
                        src_d = 8'h00;
                    end
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
        pend_d = (pend_q & ~clr_bits & ~gclr) | BotInterrupt;
        ovr_d  = (ovr_q & ~clr_bits) | (BotInterrupt & pend_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
                snap_q[i]   <= '0;
                motctl_q[i] <= '0;
            end
            dataout_q <= '0;
            mask_q    <= '0;
            src_q     <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= 1'b0;
            state_q   <= IRQ_IDLE;
        end else begin
            for (int i = 0; i < NUM_BOTS; i++) begin
                snap_q[i]   <= snap_d[i];
                motctl_q[i] <= motctl_d[i];
            end
            dataout_q <= dataout_d;
            mask_q    <= mask_d;
            src_q     <= src_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

    assign DataOut   = dataout_q;
    assign Interrupt = (state_q == IRQ_REQ);

endmodule

// File: tb/tb_multi_bot_if.sv
// tb/tb_multi_bot_if.sv - directed self-checking bench for multi_bot_if with two bots
module tb_multi_bot_if;

    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    PortID = '0;
    logic [7:0]    DataIn = '0;
    logic [7:0]    DataOut;
    logic          WriteStrobe = 1'b0;
    logic          ReadStrobe = 1'b0;
    logic          Interrupt;
    logic          InterruptAck = 1'b0;
    logic [8*NB-1:0] MotCtl;
    logic [8*NB-1:0] LocX = '0, LocY = '0, BotInfo = '0, Sensors = '0, LMDist = '0, RMDist = '0;
    logic [NB-1:0]   BotInterrupt = '0;

    int passed = 0;
    int total  = 0;
    logic [7:0] d;

    multi_bot_if #(.NUM_BOTS(NB), .BASE_PORT(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .PortID       (PortID),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .WriteStrobe  (WriteStrobe),
        .ReadStrobe   (ReadStrobe),
        .Interrupt    (Interrupt),
        .InterruptAck (InterruptAck),
        .MotCtl       (MotCtl),
        .LocX         (LocX),
        .LocY         (LocY),
        .BotInfo      (BotInfo),
        .Sensors      (Sensors),
        .LMDist       (LMDist),
        .RMDist       (RMDist),
        .BotInterrupt (BotInterrupt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] v);
        PortID = p;
        DataIn = v;
        WriteStrobe = 1'b1;
        tick();
        WriteStrobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        PortID = p;
        ReadStrobe = 1'b1;
        tick();
        tick();
        ReadStrobe = 1'b0;
        v = DataOut;
    endtask

    task automatic pulse(input logic [NB-1:0] m);
        BotInterrupt = m;
        tick();
        BotInterrupt = '0;
    endtask

    task automatic ack();
        InterruptAck = 1'b1;
        tick();
        InterruptAck = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_dataout", 16'(DataOut), 16'h00);
        chk("rst_irq", 16'(Interrupt), 16'h0);
        chk("rst_motctl", MotCtl, 16'h0000);
        rst = 1'b1;
        tick();
        for (int p = 0; p < 8'h48; p++) begin
            rd(8'(p), d);
            chk($sformatf("rst_rd_%02h", p), 16'(d), 16'h00);
        end
        chk("rst_irq_after", 16'(Interrupt), 16'h0);
        chk("rst_motctl_after", MotCtl, 16'h0000);

        // MotCtl write and readback
        wr(8'h0F, 8'h33);
        chk("motctl1_out", MotCtl, 16'h3300);
        rd(8'h0F, d);
        chk("motctl1_rd", 16'(d), 16'h33);

        // unmapped writes ignored
        wr(8'h17, 8'h55);
        rd(8'h17, d);
        chk("unmapped_bot2", 16'(d), 16'h00);
        wr(8'h45, 8'hFF);
        rd(8'h45, d);
        chk("unmapped_st45", 16'(d), 16'h00);

        // snapshot capture and stability
        LocX = 16'h005A;
        LocY = 16'h0012;
        RMDist = 16'h00C3;
        pulse(2'b01);
        LocX = 16'h0011;
        LocY = 16'h0099;
        rd(8'h00, d);
        chk("snap_locx", 16'(d), 16'h5A);
        rd(8'h01, d);
        chk("snap_locy", 16'(d), 16'h12);
        rd(8'h05, d);
        chk("snap_rmdist", 16'(d), 16'hC3);
        rd(8'h06, d);
        chk("snap_off6", 16'(d), 16'h00);
        rd(8'h08, d);
        chk("snap_bot1_locx", 16'(d), 16'h00);
        rd(8'h40, d);
        chk("pend_masked", 16'(d), 16'h01);
        chk("irq_masked", 16'(Interrupt), 16'h0);
        wr(8'h43, 8'h01);
        rd(8'h40, d);
        chk("pend_cleared", 16'(d), 16'h00);

        // round-robin service of two simultaneous requests
        wr(8'h42, 8'h03);
        rd(8'h42, d);
        chk("mask_rd", 16'(d), 16'h03);
        pulse(2'b11);
        chk("irq_edge_n", 16'(Interrupt), 16'h0);
        tick();
        chk("irq_edge_n1", 16'(Interrupt), 16'h1);
        rd(8'h40, d);
        chk("pend_both", 16'(d), 16'h03);
        chk("irq_held", 16'(Interrupt), 16'h1);
        ack();
        chk("irq_after_ack1", 16'(Interrupt), 16'h0);
        PortID = 8'h41;
        tick();
        chk("irq_gap", 16'(Interrupt), 16'h0);
        tick();
        chk("irq_rearm", 16'(Interrupt), 16'h1);
        chk("src_first", 16'(DataOut), 16'h80);
        ack();
        chk("irq_after_ack2", 16'(Interrupt), 16'h0);
        rd(8'h41, d);
        chk("src_second", 16'(d), 16'h81);
        chk("irq_idle", 16'(Interrupt), 16'h0);
        rd(8'h40, d);
        chk("pend_end", 16'(d), 16'h00);
        rd(8'h44, d);
        chk("ovr_none", 16'(d), 16'h00);

        // overrun and write-1-to-clear
        wr(8'h42, 8'h00);
        pulse(2'b01);
        tick();
        pulse(2'b01);
        rd(8'h40, d);
        chk("ovr_pend", 16'(d), 16'h01);
        rd(8'h44, d);
        chk("ovr_set", 16'(d), 16'h01);
        wr(8'h43, 8'h01);
        rd(8'h40, d);
        chk("ovr_pend_clr", 16'(d), 16'h00);
        rd(8'h44, d);
        chk("ovr_clr", 16'(d), 16'h00);
        rd(8'h41, d);
        chk("src_sticky", 16'(d), 16'h81);

        // set wins over same-cycle clear
        BotInterrupt = 2'b01;
        wr(8'h43, 8'h01);
        BotInterrupt = '0;
        rd(8'h40, d);
        chk("set_over_clr", 16'(d), 16'h01);
        rd(8'h44, d);
        chk("set_over_clr_ovr", 16'(d), 16'h00);

        // request vanishes before ack
        wr(8'h42, 8'h01);
        chk("vanish_pre", 16'(Interrupt), 16'h0);
        tick();
        chk("vanish_req", 16'(Interrupt), 16'h1);
        wr(8'h42, 8'h00);
        chk("vanish_held", 16'(Interrupt), 16'h1);
        ack();
        chk("vanish_ack_irq", 16'(Interrupt), 16'h0);
        rd(8'h41, d);
        chk("vanish_src", 16'(d), 16'h00);
        rd(8'h40, d);
        chk("vanish_pend", 16'(d), 16'h01);

        // asynchronous mid-operation reset
        wr(8'h07, 8'h44);
        rd(8'h0F, d);
        chk("pre_rst_rd", 16'(d), 16'h33);
        chk("pre_rst_motctl", MotCtl, 16'h3344);
        rst = 1'b0;
        #2;
        chk("async_motctl", MotCtl, 16'h0000);
        chk("async_dataout", 16'(DataOut), 16'h00);
        chk("async_irq", 16'(Interrupt), 16'h0);
        tick();
        rst = 1'b1;
        tick();
        rd(8'h40, d);
        chk("post_rst_pend", 16'(d), 16'h00);
        rd(8'h00, d);
        chk("post_rst_snap", 16'(d), 16'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
